// File: rtl/sdr_access_arbiter_if.sv
// Request/bridge bundle for sdr_access_arbiter: requester handshake on one side,
// HPS SDRAM burst bridge on the other.
interface sdr_access_arbiter_if #(
  parameter int NREQ = 2,
  parameter int DW   = 2048,
  parameter int AW   = 32,
  parameter int NW   = 30
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*NW-1:0] req_nelems;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_done;
  logic [NREQ-1:0]    req_err;
  logic [DW-1:0]      rdata;
  logic               busy;

  logic [AW-1:0]      sdr_baseaddr;
  logic [NW-1:0]      sdr_nelems;
  logic               sdr_readstart;
  logic               sdr_writestart;
  logic [DW-1:0]      sdr_writedata;
  logic               sdr_readend;
  logic               sdr_writeend;
  logic [DW-1:0]      sdr_readdata;

  // The arbiter side drives grants/results and the bridge command.
  modport master (
    input  req_valid, req_write, req_addr, req_nelems, req_wdata,
    input  sdr_readend, sdr_writeend, sdr_readdata,
    output req_ready, req_done, req_err, rdata, busy,
    output sdr_baseaddr, sdr_nelems, sdr_readstart, sdr_writestart, sdr_writedata
  );

  // Requesters and bridge together.
  modport slave (
    output req_valid, req_write, req_addr, req_nelems, req_wdata,
    output sdr_readend, sdr_writeend, sdr_readdata,
    input  req_ready, req_done, req_err, rdata, busy,
    input  sdr_baseaddr, sdr_nelems, sdr_readstart, sdr_writestart, sdr_writedata
  );
endinterface

// File: rtl/sdr_access_arbiter.sv
// Round-robin arbiter sharing one SDRAM burst bridge among NREQ requesters,
// one burst outstanding, with start-pulse generation and a completion watchdog.
module sdr_access_arbiter #(
  parameter int NREQ    = 2,
  parameter int DW      = 2048,
  parameter int AW      = 32,
  parameter int NW      = 30,
  parameter int TIMEOUT = 65535
) (
  input  logic                 sdr_clk,
  input  logic                 sdr_reset_n,
  sdr_access_arbiter_if.master bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t        state, state_next;
  logic [IW-1:0] rr_ptr, gnt, gnt_idx;
  logic          gnt_found;
  logic          cur_write, zero_len;
  logic          end_hit, wd_expired, finish, expire;
  logic [31:0]   wd;

  // First valid requester after the last one served, wrapping.
  always_comb begin : arbitrate
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr;
    for (int k = 1; k <= NREQ; k++) begin
      if (!gnt_found && bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign end_hit    = cur_write ? bus.sdr_writeend : bus.sdr_readend;
  assign wd_expired = (TIMEOUT != 0) && (wd == 32'(TIMEOUT));

  // A zero-length burst walks START/WAIT with the start pulse suppressed and
  // completes in WAIT, so the bridge is never touched.
  always_comb begin : fsm_next
    // NOTE: every variable gets a default first so no path infers a latch.
    state_next = state;
    finish     = 1'b0;
    expire     = 1'b0;
    unique case (state)
      S_IDLE: if (gnt_found) state_next = S_START;
      S_START, S_WAIT: begin
        if (zero_len)        finish = (state == S_WAIT);
        else if (end_hit)    finish = 1'b1;
        else if (wd_expired) expire = 1'b1;
        state_next = (finish || expire) ? S_DONE : S_WAIT;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge sdr_clk or negedge sdr_reset_n) begin
    if (!sdr_reset_n) begin
      state              <= S_IDLE;
      rr_ptr             <= IW'(NREQ - 1);
      gnt                <= '0;
      cur_write          <= 1'b0;
      zero_len           <= 1'b0;
      wd                 <= '0;
      bus.req_ready      <= '0;
      bus.req_done       <= '0;
      bus.req_err        <= '0;
      bus.rdata          <= '0;
      bus.busy           <= 1'b0;
      bus.sdr_baseaddr   <= '0;
      bus.sdr_nelems     <= '0;
      bus.sdr_readstart  <= 1'b0;
      bus.sdr_writestart <= 1'b0;
      bus.sdr_writedata  <= '0;
    end else begin
      state              <= state_next;
      bus.busy           <= (state_next != S_IDLE);
      bus.req_ready      <= '0;
      bus.req_done       <= '0;
      bus.req_err        <= '0;
      bus.sdr_readstart  <= 1'b0;
      bus.sdr_writestart <= 1'b0;
      wd                 <= (state == S_START || state == S_WAIT) ? wd + 32'd1 : 32'd0;

      if (state == S_IDLE && gnt_found) begin
        gnt                    <= gnt_idx;
        cur_write              <= bus.req_write[gnt_idx];
        zero_len               <= (bus.req_nelems[int'(gnt_idx)*NW +: NW] == '0);
        bus.sdr_baseaddr       <= bus.req_addr[int'(gnt_idx)*AW +: AW];
        bus.sdr_nelems         <= bus.req_nelems[int'(gnt_idx)*NW +: NW];
        bus.sdr_writedata      <= bus.req_wdata[int'(gnt_idx)*DW +: DW];
        bus.req_ready[gnt_idx] <= 1'b1;
        if (bus.req_nelems[int'(gnt_idx)*NW +: NW] != '0) begin
          bus.sdr_readstart  <= !bus.req_write[gnt_idx];
          bus.sdr_writestart <= bus.req_write[gnt_idx];
        end
      end

      if (finish) begin
        bus.req_done[gnt] <= 1'b1;
        rr_ptr            <= gnt;
        if (!cur_write && !zero_len) bus.rdata <= bus.sdr_readdata;
      end

      if (expire) begin
        bus.req_err[gnt] <= 1'b1;
        rr_ptr           <= gnt;
      end
    end
  end
endmodule
